// File: rtl/uart_rx_pkg.sv
// Shared definitions for the uart_rx receiver: FSM state encodings and the
// minimum clocks-per-bit divisor.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_e;

  localparam int UART_DIV_MIN = 4;

endpackage

// File: rtl/uart_rx_fifo.sv
// Small first-word-fall-through receive FIFO, DEPTH x 8.
// Pointers carry one extra bit so full and empty are distinguishable.
module uart_rx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_n,
  input  logic       push_i,
  input  logic [7:0] din_i,
  input  logic       pop_i,
  output logic [7:0] dout_o,
  output logic       full_o,
  output logic       empty_o,
  output logic       overrun_o
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wptr_q, rptr_q;
  logic        overrun_q;
  logic        pop, wr;

  assign empty_o   = (wptr_q == rptr_q);
  assign full_o    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop       = pop_i & ~empty_o;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign wr        = push_i & (~full_o | pop);
  assign dout_o    = mem_q[rptr_q[AW-1:0]];
  assign overrun_o = overrun_q;

  // Storage, pointers and the registered overrun pulse.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (wr) begin
        mem_q[wptr_q[AW-1:0]] <= din_i;
        wptr_q                <= wptr_q + 1'b1;
      end
      if (pop) rptr_q <= rptr_q + 1'b1;
      overrun_q <= push_i & full_o & ~pop;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8-bit async serial receiver: 2-flop synchroniser, down-counting bit timer
// sampling mid-bit, LSB-first shift, FWFT receive FIFO.
// Define UART_RX_PARITY_EN for an 8-data + parity + stop frame (default 8N1).
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] divisor,
  input  logic             rx_i,
  input  logic             rd_i,
  output logic [7:0]       data_o,
  output logic             valid_o,
  output logic             frame_err_o,
  output logic             overrun_o,
`ifdef UART_RX_PARITY_EN
  input  logic             parity_odd_i,
  output logic             parity_err_o,
`endif
  output logic             busy_o
);

  rx_state_e        state_q, state_d;
  logic [1:0]       sync_q;
  logic [DIV_W-1:0] cnt_q, cnt_d, div_eff;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             fe_q, fe_d;
  logic             push, empty, full, rx_s, tick;
`ifdef UART_RX_PARITY_EN
  logic             perr_q, perr_d;
  logic             pe_q, pe_d;
`endif

  assign rx_s    = sync_q[1];
  assign tick    = (cnt_q == '0);
  assign div_eff = (divisor < DIV_W'(UART_DIV_MIN)) ? DIV_W'(UART_DIV_MIN) : divisor;

  // Two-flop synchroniser for the asynchronous line; idles high.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], rx_i};
  end

  // Receiver state, bit timer, shift register and error pulses.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      fe_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
      pe_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      fe_q    <= fe_d;
`ifdef UART_RX_PARITY_EN
      perr_q  <= perr_d;
      pe_q    <= pe_d;
`endif
    end
  end

  // Next-state logic; divisor is only consulted when the timer reloads.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    fe_d    = 1'b0;
    push    = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d  = perr_q;
    pe_d    = 1'b0;
`endif
    if (state_q != ST_IDLE && state_q != ST_BREAK)
      cnt_d = tick ? (div_eff - DIV_W'(1)) : (cnt_q - DIV_W'(1));
    case (state_q)
      ST_IDLE: if (!rx_s) begin
        cnt_d   = div_eff >> 1;
        state_d = ST_START;
`ifdef UART_RX_PARITY_EN
        perr_d  = 1'b0;
`endif
      end
      ST_START: if (tick) begin
        if (rx_s) state_d = ST_IDLE;
        else begin
          state_d = ST_DATA;
          idx_d   = 3'd0;
        end
      end
      ST_DATA: if (tick) begin
        shift_d[idx_q] = rx_s;
        idx_d          = idx_q + 3'd1;
        if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: if (tick) begin
        perr_d  = (rx_s != (^shift_q ^ parity_odd_i));
        state_d = ST_STOP;
      end
`endif
      ST_STOP: if (tick) begin
        if (rx_s) begin
          state_d = ST_IDLE;
`ifdef UART_RX_PARITY_EN
          if (perr_q) pe_d = 1'b1;
          else
`endif
          push = 1'b1;
        end else begin
          fe_d    = 1'b1;
          state_d = ST_BREAK;
        end
      end
      // A held-low line must return high before another start is accepted.
      ST_BREAK: if (rx_s) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i     (clk_i),
    .rst_n     (rst_n),
    .push_i    (push),
    .din_i     (shift_q),
    .pop_i     (rd_i),
    .dout_o    (data_o),
    .full_o    (full),
    .empty_o   (empty),
    .overrun_o (overrun_o)
  );

  assign valid_o     = ~empty;
  assign frame_err_o = fe_q;
  assign busy_o      = (state_q != ST_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err_o = pe_q;
`endif

  logic unused_full;
  assign unused_full = full;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at divisor=16.
module tb_uart_rx;

`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  // Start sample lands 11 cycles after the falling edge; stop sample 11 into the stop bit.
  localparam int STOP_SMP = (NB - 1) * 16 + 11;

  logic        clk = 1'b0, rst_n = 1'b0, rx = 1'b1, rd = 1'b0;
  logic [15:0] divisor = 16'd16;
  logic [7:0]  data;
  logic        valid, ferr, oerr, busy;
  int          n_chk = 0, n_pass = 0;
  int          fe_cnt = 0, oe_cnt = 0, pe_cnt = 0;
`ifdef UART_RX_PARITY_EN
  logic        par_odd = 1'b0, perr;
`endif

  uart_rx dut (
    .clk_i       (clk),
    .rst_n       (rst_n),
    .divisor     (divisor),
    .rx_i        (rx),
    .rd_i        (rd),
    .data_o      (data),
    .valid_o     (valid),
    .frame_err_o (ferr),
    .overrun_o   (oerr),
`ifdef UART_RX_PARITY_EN
    .parity_odd_i(par_odd),
    .parity_err_o(perr),
`endif
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ferr) fe_cnt++;
    if (oerr) oe_cnt++;
`ifdef UART_RX_PARITY_EN
    if (perr) pe_cnt++;
`endif
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Drive one frame; rd_i is pulsed in cycle rd_at (-1 = never).
  task automatic send(input logic [7:0] d, input logic stop, input logic pbit, input int rd_at);
    logic [NB-1:0] bits;
    bits         = '0;
    bits[8:1]    = d;
`ifdef UART_RX_PARITY_EN
    bits[9]      = pbit;
`else
    if (pbit) bits[0] = 1'b0;
`endif
    bits[NB-1]   = stop;
    for (int b = 0; b < NB; b++)
      for (int c = 0; c < 16; c++) begin
        @(negedge clk);
        rx = bits[b];
        rd = ((b * 16 + c) == rd_at);
      end
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic send_ok(input logic [7:0] d);
    send(d, 1'b1, ^d, -1);
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    @(negedge clk);
    chk({tag, "_valid"}, valid, 1'b1);
    chk({tag, "_data"}, data, exp);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Reset state
    idle(3);
    chk("rst_data", data, 8'h00);
    chk("rst_valid", valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ferr", ferr, 1'b0);
    chk("rst_oerr", oerr, 1'b0);
    rst_n = 1'b1;
    idle(5);

    // 0x48: valid only after the stop sample
    fork
      send_ok(8'h48);
      begin
        idle(STOP_SMP - 6);
        chk("t1_valid_early", valid, 1'b0);
        chk("t1_busy", busy, 1'b1);
      end
    join
    chk("t1_valid", valid, 1'b1);
    chk("t1_data", data, 8'h48);
    rd = 1'b1; @(negedge clk); rd = 1'b0;
    chk("t1_popped", valid, 1'b0);
    idle(10);

    // Glitch: 4 low cycles abort the start bit
    rx = 1'b0; idle(4); rx = 1'b1;
    idle(5);
    chk("t2_busy_during", busy, 1'b1);
    idle(20);
    chk("t2_busy", busy, 1'b0);
    chk("t2_valid", valid, 1'b0);
    chk("t2_fe", fe_cnt, 0);
    chk("t2_oe", oe_cnt, 0);

    // Framing error then long break, then a good byte
    send(8'h55, 1'b0, ^8'h55, -1);
    idle(100);
    chk("t3_fe", fe_cnt, 1);
    chk("t3_busy_break", busy, 1'b1);
    chk("t3_nopush", valid, 1'b0);
    rx = 1'b1; idle(20);
    chk("t3_idle", busy, 1'b0);
    send_ok(8'h31);
    idle(5);
    chk("t3_fe_after", fe_cnt, 1);
    pop_chk("t3_b", 8'h31);
    chk("t3_empty", valid, 1'b0);

    // Overrun at byte 5
    for (int i = 1; i <= 4; i++) send_ok(8'(i));
    idle(3);
    chk("t4_oe_before", oe_cnt, 0);
    send_ok(8'h05);
    idle(3);
    chk("t4_oe", oe_cnt, 1);
    for (int i = 1; i <= 4; i++) pop_chk("t4_b", 8'(i));
    chk("t4_empty", valid, 1'b0);

    // Full FIFO, pop in the push cycle of byte 5: no overrun
    for (int i = 1; i <= 4; i++) send_ok(8'(i));
    send(8'h05, 1'b1, ^8'h05, STOP_SMP);
    idle(3);
    chk("t5_oe", oe_cnt, 1);
    for (int i = 2; i <= 5; i++) pop_chk("t5_b", 8'(i));
    chk("t5_empty", valid, 1'b0);

    // Reset mid-DATA of 0xA5
    @(negedge clk); rx = 1'b0; idle(16);
    rx = 1'b1; idle(16);
    rx = 1'b0; idle(16);
    rx = 1'b1; idle(8);
    chk("t6_busy_pre", busy, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_busy_rst", busy, 1'b0);
    chk("t6_valid_rst", valid, 1'b0);
    idle(3);
    rst_n = 1'b1;
    idle(200);
    chk("t6_valid_idle", valid, 1'b0);
    send_ok(8'h3C);
    idle(3);
    pop_chk("t6_b", 8'h3C);
    chk("t6_empty", valid, 1'b0);
    chk("t6_fe", fe_cnt, 1);
    chk("t6_oe", oe_cnt, 1);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 needs parity bit 1; send 0 instead
    par_odd = 1'b0;
    send(8'h07, 1'b1, 1'b0, -1);
    idle(3);
    chk("t7_pe", pe_cnt, 1);
    chk("t7_nopush", valid, 1'b0);
    send(8'h07, 1'b1, 1'b1, -1);
    idle(3);
    chk("t7_pe_ok", pe_cnt, 1);
    pop_chk("t7_b", 8'h07);
`endif

    chk("end_pe", pe_cnt, 0 `ifdef UART_RX_PARITY_EN + 1 `endif);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
